alu_key_sequencer: RTL
======================

# alu_key_sequencer

Operand/opcode entry stage sitting directly upstream of the 4-bit ALU on the STEP MAX10 board. It debounces one push-button and captures the slide switches on each press: first operand A, then operand B, then the 3-bit opcode. It then drives `a`, `b` and `alusel` into the ALU as registered, stable values, replacing the ALU's hard-coded operands. Further presses step through the opcodes, or restart entry.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required to accept a key level change (20 ms at 12 MHz). Legal range 2..2^20-1.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; the block has one clock.
- `key_n`  in  1  raw push-button, low = pressed, asynchronous, bouncy.
- `sw`  in  4  raw slide switches, asynchronous, quasi-static.
- `a`  out  4  operand A to ALU.
- `b`  out  4  operand B to ALU.
- `alusel`  out  3  opcode to ALU (000 pass A, 001 add, 010 A-B, 011 B-A, 100 NOT, 101 AND, 110 OR, 111 XOR).
- `valid`  out  1  high when `a`, `b` and `alusel` form a complete, committed operation.
- `stage`  out  2  current entry state encoding, intended for status LEDs.

## Operation
- Input sync: `key_n` and `sw` each pass through a 2-flop synchronizer. The key synchronizer resets to 1; the switch synchronizer resets to 0.
- Debounce:
  - `key_stable` resets to 1.
  - A 20-bit counter clears whenever synced key equals `key_stable`. Otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while synced key still differs, `key_stable` takes the synced value and the counter clears.
  - Any glitch back to the `key_stable` level before that point clears the counter, and no change is accepted.
- Press event: a single-cycle internal pulse `press` when `key_stable` goes 1->0. Release (0->1) produces no event.
- FSM states, with their `stage` encoding:
  - S_A = 00. On `press`: `a <= sw_sync`, go to S_B.
  - S_B = 01. On `press`: `b <= sw_sync`, go to S_OP.
  - S_OP = 10. On `press`: `alusel <= sw_sync[2:0]`, `valid <= 1`, go to S_RUN.
  - S_RUN = 11. On `press` with `sw_sync[3]=0`: `alusel <= alusel+1`, wrapping 111->000, and `valid` stays 1. On `press` with `sw_sync[3]=1`: `valid <= 0`, go to S_A. `a`, `b` and `alusel` keep their old values until recaptured.
  - With no `press`, the state and all outputs hold.
- Outputs not being written in a given state hold their values. For example, `b` keeps its old value while in S_A.
- `valid` is 0 in S_A, S_B and S_OP, and 1 only in S_RUN.
- Arithmetic: only the `alusel` increment (3-bit modulo 8) and the debounce counter. There is no saturation other than the counter clear.

## Timing
- Reset values (asynchronous assert, applied immediately): `a=0`, `b=0`, `alusel=000`, `valid=0`, `stage=00` (S_A), `key_stable=1`, counter=0.
- Reset mid-entry: the FSM returns to S_A and all partial captures are discarded.
- Release of `rst_n` is synchronized externally. The first active edge after deassert treats the key as released.
- Key latency: if `key_n` goes low before edge 0 and stays low, then:
  - synced key is low after edge 1;
  - `key_stable` falls at edge 1+`DEBOUNCE_CYCLES`;
  - `press` is high for the following cycle;
  - outputs and `stage` update at edge 2+`DEBOUNCE_CYCLES`.
- Switch setup: `sw` must be stable at least 3 cycles before the `press` edge to be captured.
- Holding the key produces exactly one `press`. The next press requires a debounced release followed by a debounced press.
- Minimum press spacing: 2*`DEBOUNCE_CYCLES`+2 cycles.
- All outputs are registered. `a`, `b`, `alusel` and `valid` change on the same edge, with no combinational path from inputs to outputs.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES=4`.
- **Reset:** assert `rst_n=0` mid-run -> outputs read a=0, b=0, alusel=0, valid=0, stage=00 without waiting for a clock edge.
- **Full entry:** clean presses with sw=0101, then 0010, then 0001 -> a=0101, b=0010, alusel=001, valid=1, stage=11. Each update lands exactly 6 edges after `key_n` falls.
- **Bounce rejection:** in S_A, toggle `key_n` low for 3 cycles, then high, five times -> no state change. Then hold low for 10 cycles with sw=1111 -> exactly one capture, a=1111, stage=01.
- **Opcode stepping and wrap:** in S_RUN with alusel=110 and sw[3]=0, press twice -> alusel=111, then 000, with valid held at 1 and a/b unchanged.
- **Restart:** in S_RUN, press with sw=1000 -> valid=0, stage=00, and a/b/alusel retain their prior values. The next press with sw=0011 sets a=0011.
- **Long hold:** hold `key_n` low for 100 cycles in S_B -> exactly one capture. After release and a new press, the FSM advances exactly one more state.

Source files
------------

// File: rtl/alu_key_sequencer.sv
// alu_key_sequencer: debounced single-key entry of operand A, operand B and
// opcode for the downstream 4-bit ALU. Each accepted key press captures the
// synchronized slide switches into the next field; in the run state further
// presses step the opcode or restart entry. All outputs are registered.
module alu_key_sequencer #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic [3:0] sw,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] alusel,
    output logic       valid,
    output logic [1:0] stage
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_e;

    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    logic        key_meta_q;
    logic        key_sync_q;
    logic [3:0]  sw_meta_q;
    logic [3:0]  sw_sync_q;
    logic        key_stable_q;
    logic        key_stable_d;
    logic        key_stable_dly_q;
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;
    logic        press_s;

    state_e      state_q;
    state_e      state_d;
    logic [3:0]  a_q;
    logic [3:0]  a_d;
    logic [3:0]  b_q;
    logic [3:0]  b_d;
    logic [2:0]  sel_q;
    logic [2:0]  sel_d;
    logic        valid_q;
    logic        valid_d;

    // Two-flop synchronizers; the key idles released (1), switches idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sw_meta_q  <= 4'b0000;
            sw_sync_q  <= 4'b0000;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Debounce: accept a new key level only after it has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts.
    always_comb begin
        key_stable_d = key_stable_q;
        cnt_d        = 20'd0;
        if (key_sync_q == key_stable_q) begin
            cnt_d = 20'd0;
        end else if (cnt_q == CNT_MAX) begin
            key_stable_d = key_sync_q;
            cnt_d        = 20'd0;
        end else begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    // Debounce state plus a delayed copy of the stable level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable_q     <= 1'b1;
            key_stable_dly_q <= 1'b1;
            cnt_q            <= 20'd0;
        end else begin
            key_stable_q     <= key_stable_d;
            key_stable_dly_q <= key_stable_q;
            cnt_q            <= cnt_d;
        end
    end

    // One-cycle press pulse on the debounced falling edge; release is ignored.
    assign press_s = key_stable_dly_q & ~key_stable_q;

    // Entry FSM next-state and capture logic; everything holds without a press.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (press_s) begin
            case (state_q)
                S_A: begin
                    a_d     = sw_sync_q;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_sync_q;
                    state_d = S_OP;
                end
                S_OP: begin
                    sel_d   = sw_sync_q[2:0];
                    valid_d = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (sw_sync_q[3]) begin
                        valid_d = 1'b0;
                        state_d = S_A;
                    end else begin
                        sel_d   = sel_q + 3'd1;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_A;
                    valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= 4'b0000;
            b_q     <= 4'b0000;
            sel_q   <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign alusel = sel_q;
    assign valid  = valid_q;
    assign stage  = state_q;

endmodule
